// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// NOP opcode and default address width.
package fetch_sequencer_pkg;

    localparam int unsigned DEFAULT_PC_W = 16;
    localparam int unsigned INST_W       = 8;

    localparam logic [INST_W-1:0] NOP_OPCODE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE_RST = 2'b00,
        ST_FETCH    = 2'b01,
        ST_EXEC     = 2'b10,
        ST_UNUSED   = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Next program counter: jump destination or sequential increment (wraps at 2^PC_W).
module fetch_sequencer_pc_next
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned PC_W = DEFAULT_PC_W
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_jump,
    input  logic [PC_W-1:0] i_jump_target,
    output logic [PC_W-1:0] o_pc_next_c
);

    assign o_pc_next_c = i_jump ? i_jump_target : i_pc + PC_W'(1);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns pc, instruction register and decode phase bit; fetches
// over a req/ack ROM port. Optional fetch-wait timeout under FETCH_TIMEOUT_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W           = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC       = '0,
    parameter int unsigned     TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_req,
    output logic [PC_W-1:0]   rom_addr,
    input  logic              rom_ack,
    input  logic [INST_W-1:0] rom_data,
    input  logic              two_cycle,
    input  logic              stall,
    input  logic              jump,
    input  logic [PC_W-1:0]   jump_target,
    output logic [INST_W-1:0] inst,
    output logic              cycle,
    output logic              inst_valid,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_err
);

    fetch_state_t      r_state;
    logic [PC_W-1:0]   r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_cycle;
    logic              r_inst_valid;
    logic              r_rom_req;
    logic              r_fetch_err;
    logic [PC_W-1:0]   w_pc_next;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
    logic [WAIT_W-1:0] r_wait;
`endif

    fetch_sequencer_pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .i_pc          (r_pc),
        .i_jump        (jump),
        .i_jump_target (jump_target),
        .o_pc_next_c   (w_pc_next)
    );

    // Fetch/execute sequencing; stall freezes every execute-phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_inst       <= NOP_OPCODE;
            r_cycle      <= 1'b0;
            r_inst_valid <= 1'b0;
            r_rom_req    <= 1'b0;
            r_fetch_err  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_wait       <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE_RST: begin
                    r_rom_req <= 1'b1;
                    r_state   <= ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    r_wait    <= '0;
`endif
                end
                ST_FETCH: begin
                    // Reset leaves FETCH with req low; the first edge raises it.
                    if (!r_rom_req) begin
                        r_rom_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        r_wait    <= '0;
`endif
                    end else if (rom_ack) begin
                        r_inst       <= rom_data;
                        r_cycle      <= 1'b0;
                        r_inst_valid <= 1'b1;
                        r_rom_req    <= 1'b0;
                        r_state      <= ST_EXEC;
`ifdef FETCH_TIMEOUT_EN
                    end else if (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_fetch_err  <= 1'b1;
                        r_inst       <= NOP_OPCODE;
                        r_cycle      <= 1'b0;
                        r_inst_valid <= 1'b1;
                        r_rom_req    <= 1'b0;
                        r_state      <= ST_EXEC;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
`endif
                    end
                end
                ST_EXEC: begin
                    if (stall) begin
                        r_state <= ST_EXEC;
                    end else if (!r_cycle && two_cycle) begin
                        r_cycle <= 1'b1;
                    end else begin
                        r_pc         <= w_pc_next;
                        r_inst_valid <= 1'b0;
                        r_cycle      <= 1'b0;
                        r_rom_req    <= 1'b1;
                        r_state      <= ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                        r_wait       <= '0;
`endif
                    end
                end
                default: begin
                    r_inst_valid <= 1'b0;
                    r_cycle      <= 1'b0;
                    r_rom_req    <= 1'b1;
                    r_state      <= ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    r_wait       <= '0;
`endif
                end
            endcase
        end
    end

    assign rom_req    = r_rom_req;
    assign rom_addr   = r_pc;
    assign inst       = r_inst;
    assign cycle      = r_cycle;
    assign inst_valid = r_inst_valid;
    assign pc         = r_pc;
    assign fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table plus reset and
// fetch-timeout sequences (timeout checks depend on FETCH_TIMEOUT_EN).
module tb_fetch_sequencer;

    localparam int unsigned PC_W = 16;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rom_req;
    logic [PC_W-1:0] rom_addr;
    logic            rom_ack = 1'b0;
    logic [7:0]      rom_data = 8'h00;
    logic            two_cycle = 1'b0;
    logic            stall = 1'b0;
    logic            jump = 1'b0;
    logic [PC_W-1:0] jump_target = '0;
    logic [7:0]      inst;
    logic            cycle;
    logic            inst_valid;
    logic [PC_W-1:0] pc;
    logic            fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_sequencer #(
        .PC_W           (PC_W),
        .RESET_PC       (16'h0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .two_cycle   (two_cycle),
        .stall       (stall),
        .jump        (jump),
        .jump_target (jump_target),
        .inst        (inst),
        .cycle       (cycle),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [7:0]  inst;
        logic        cyc;
        logic        val;
        logic [15:0] pc;
        logic        err;
    } exp_t;

    typedef struct {
        logic        ack;
        logic [7:0]  data;
        logic        two;
        logic        stall;
        logic        jmp;
        logic [15:0] tgt;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[26];

    function automatic vec_t mk(input logic ack, input logic [7:0] data,
                                input logic two, input logic stl, input logic jmp,
                                input logic [15:0] tgt, input logic req,
                                input logic [7:0] ins, input logic cyc,
                                input logic val, input logic [15:0] p,
                                input logic err);
        vec_t v;
        v.ack = ack; v.data = data; v.two = two; v.stall = stl;
        v.jmp = jmp; v.tgt = tgt;
        v.e.req = req; v.e.inst = ins; v.e.cyc = cyc; v.e.val = val;
        v.e.pc = p; v.e.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".rom_req"},    32'(rom_req),    32'(e.req));
        if (e.req)
            chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(e.pc));
        chk({tag, ".inst"},       32'(inst),       32'(e.inst));
        chk({tag, ".cycle"},      32'(cycle),      32'(e.cyc));
        chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(e.val));
        chk({tag, ".pc"},         32'(pc),         32'(e.pc));
        chk({tag, ".fetch_err"},  32'(fetch_err),  32'(e.err));
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        rom_ack     = v.ack;
        rom_data    = v.data;
        two_cycle   = v.two;
        stall       = v.stall;
        jump        = v.jmp;
        jump_target = v.tgt;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_out(tag, e);
    endtask

    initial begin
        exp_t rst_e;
        rst_e.req = 1'b0; rst_e.inst = 8'h00; rst_e.cyc = 1'b0;
        rst_e.val = 1'b0; rst_e.pc = 16'h0000; rst_e.err = 1'b0;

        //         ack data  two stl jmp tgt       req inst cyc val pc       err
        tbl[0]  = mk(1, 8'hEE, 0, 0, 0, 16'h0000, 1, 8'h00, 0, 0, 16'h0000, 0);
        tbl[1]  = mk(1, 8'h12, 0, 0, 0, 16'h0000, 0, 8'h12, 0, 1, 16'h0000, 0);
        tbl[2]  = mk(1, 8'hFF, 0, 0, 0, 16'h0000, 1, 8'h12, 0, 0, 16'h0001, 0);
        tbl[3]  = mk(1, 8'h34, 0, 0, 0, 16'h0000, 0, 8'h34, 0, 1, 16'h0001, 0);
        tbl[4]  = mk(1, 8'hFF, 0, 0, 0, 16'h0000, 1, 8'h34, 0, 0, 16'h0002, 0);
        tbl[5]  = mk(1, 8'hA5, 0, 0, 0, 16'h0000, 0, 8'hA5, 0, 1, 16'h0002, 0);
        tbl[6]  = mk(1, 8'hFF, 1, 0, 0, 16'h0000, 0, 8'hA5, 1, 1, 16'h0002, 0);
        tbl[7]  = mk(1, 8'hFF, 1, 0, 0, 16'h0000, 1, 8'hA5, 0, 0, 16'h0003, 0);
        tbl[8]  = mk(1, 8'h77, 0, 0, 1, 16'h1234, 0, 8'h77, 0, 1, 16'h0003, 0);
        tbl[9]  = mk(1, 8'hFF, 0, 0, 1, 16'h0040, 1, 8'h77, 0, 0, 16'h0040, 0);
        tbl[10] = mk(1, 8'h5A, 0, 0, 0, 16'h0000, 0, 8'h5A, 0, 1, 16'h0040, 0);
        tbl[11] = mk(1, 8'hFF, 1, 0, 1, 16'h0040, 0, 8'h5A, 1, 1, 16'h0040, 0);
        tbl[12] = mk(1, 8'hFF, 0, 0, 1, 16'hFFFF, 1, 8'h5A, 0, 0, 16'hFFFF, 0);
        tbl[13] = mk(1, 8'hC3, 0, 0, 0, 16'h0000, 0, 8'hC3, 0, 1, 16'hFFFF, 0);
        tbl[14] = mk(1, 8'hFF, 0, 0, 0, 16'h0000, 1, 8'hC3, 0, 0, 16'h0000, 0);
        tbl[15] = mk(0, 8'h99, 0, 0, 0, 16'h0000, 1, 8'hC3, 0, 0, 16'h0000, 0);
        tbl[16] = mk(0, 8'h99, 0, 0, 0, 16'h0000, 1, 8'hC3, 0, 0, 16'h0000, 0);
        tbl[17] = mk(0, 8'h99, 0, 0, 0, 16'h0000, 1, 8'hC3, 0, 0, 16'h0000, 0);
        tbl[18] = mk(1, 8'h3C, 0, 0, 0, 16'h0000, 0, 8'h3C, 0, 1, 16'h0000, 0);
        tbl[19] = mk(1, 8'hFF, 1, 1, 0, 16'h0000, 0, 8'h3C, 0, 1, 16'h0000, 0);
        tbl[20] = mk(1, 8'hFF, 1, 1, 1, 16'h0100, 0, 8'h3C, 0, 1, 16'h0000, 0);
        tbl[21] = mk(1, 8'hFF, 1, 0, 0, 16'h0000, 0, 8'h3C, 1, 1, 16'h0000, 0);
        tbl[22] = mk(1, 8'hFF, 0, 1, 1, 16'h0200, 0, 8'h3C, 1, 1, 16'h0000, 0);
        tbl[23] = mk(1, 8'hFF, 0, 0, 1, 16'h0100, 1, 8'h3C, 0, 0, 16'h0100, 0);
        tbl[24] = mk(1, 8'h81, 0, 0, 0, 16'h0000, 0, 8'h81, 0, 1, 16'h0100, 0);
        tbl[25] = mk(1, 8'hFF, 0, 0, 0, 16'h0000, 1, 8'h81, 0, 0, 16'h0101, 0);

        // Reset values, then release away from the clock edge.
        rom_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", rst_e);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++)
            step(tbl[i], $sformatf("row%0d", i));

        // Asynchronous reset in the middle of a fetch.
        rom_ack = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_out("midrst", rst_e);
        rom_ack  = 1'b1;
        rom_data = 8'hDE;
        @(posedge clk);
        #1;
        check_out("midrst_hold", rst_e);
        rst_n = 1'b1;
        step(mk(1, 8'hDE, 0, 0, 0, 16'h0, 1, 8'h00, 0, 0, 16'h0000, 0), "postrst0");
        step(mk(1, 8'hDE, 0, 0, 0, 16'h0, 0, 8'hDE, 0, 1, 16'h0000, 0), "postrst1");
        step(mk(0, 8'h00, 0, 0, 0, 16'h0, 1, 8'hDE, 0, 0, 16'h0001, 0), "tofetch");

        // Memory never acks: timeout substitutes a NOP after 4 wait clocks.
        if (TO_EN) begin
            for (int k = 0; k < 3; k++)
                step(mk(0, 8'h11, 0, 0, 0, 16'h0, 1, 8'hDE, 0, 0, 16'h0001, 0),
                     $sformatf("towait%0d", k));
            step(mk(0, 8'h11, 0, 0, 0, 16'h0, 0, 8'h00, 0, 1, 16'h0001, 1), "timeout");
            step(mk(1, 8'h55, 0, 0, 0, 16'h0, 1, 8'h00, 0, 0, 16'h0002, 1), "to_end");
            step(mk(1, 8'h66, 0, 0, 0, 16'h0, 0, 8'h66, 0, 1, 16'h0002, 1), "to_refetch");
        end else begin
            for (int k = 0; k < 6; k++)
                step(mk(0, 8'h11, 0, 0, 0, 16'h0, 1, 8'hDE, 0, 0, 16'h0001, 0),
                     $sformatf("nowait%0d", k));
            step(mk(1, 8'h66, 0, 0, 0, 16'h0, 0, 8'h66, 0, 1, 16'h0001, 0), "late_ack");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
